// File: rtl/exec_trace_monitor_pkg.sv
// exec_trace_monitor_pkg
//   Shared definitions for the execution-trace monitor: the FSM state
//   encoding used by the top level and visible on its `state` output.
package exec_trace_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALTED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } trace_state_e;

endpackage

// File: rtl/exec_trace_monitor_ring_buffer.sv
// trace_ring_buffer
//   Circular trace store of (pc, result) pairs with newest-relative readback.
//   Ports:
//     clk, reset         rising-edge clock, synchronous active-high reset
//     wr_en              write (wr_pc, wr_result) at the write pointer
//     rd_idx             readback index, 0 = newest entry
//     rd_pc, rd_result   selected entry, 0 when rd_idx >= entries
//     entries            number of valid entries, saturates at DEPTH
//     overflow           sticky, set when a write replaces the oldest entry
module trace_ring_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [XLEN-1:0]          wr_pc,
    input  logic [XLEN-1:0]          wr_result,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [XLEN-1:0]          rd_pc,
    output logic [XLEN-1:0]          rd_result,
    output logic [$clog2(DEPTH):0]   entries,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [XLEN-1:0] pc_mem_q  [DEPTH];
    logic [XLEN-1:0] pc_mem_d  [DEPTH];
    logic [XLEN-1:0] res_mem_q [DEPTH];
    logic [XLEN-1:0] res_mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]     entries_q, entries_d;
    logic            overflow_q, overflow_d;
    logic [AW-1:0]   rd_slot;

    always_comb begin
        pc_mem_d   = pc_mem_q;
        res_mem_d  = res_mem_q;
        wr_ptr_d   = wr_ptr_q;
        entries_d  = entries_q;
        overflow_d = overflow_q;
        if (wr_en) begin
            pc_mem_d[wr_ptr_q]  = wr_pc;
            res_mem_d[wr_ptr_q] = wr_result;
            // DEPTH is a power of two, so the pointer wraps naturally.
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (entries_q == FULL) begin
                overflow_d = 1'b1;
            end else begin
                entries_d = entries_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_mem_q   <= '{default: '0};
            res_mem_q  <= '{default: '0};
            wr_ptr_q   <= '0;
            entries_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            pc_mem_q   <= pc_mem_d;
            res_mem_q  <= res_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            entries_q  <= entries_d;
            overflow_q <= overflow_d;
        end
    end

    // Newest entry sits one slot behind the write pointer.
    assign rd_slot = wr_ptr_q - AW'(1) - rd_idx;

    always_comb begin
        rd_pc     = '0;
        rd_result = '0;
        if ({1'b0, rd_idx} < entries_q) begin
            rd_pc     = pc_mem_q[rd_slot];
            rd_result = res_mem_q[rd_slot];
        end
    end

    assign entries  = entries_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/exec_trace_monitor.sv
// exec_trace_monitor
//   Watches a (pc, result) stream, records every PC change into a ring
//   buffer, declares HALTED when the PC stays put for HALT_CYCLES qualified
//   samples and TIMEOUT after MAX_CYCLES cycles spent in RUN.
//   Ports:
//     clk, reset             rising-edge clock, synchronous active-high reset
//     sample_en              qualifies pc_in / result_in this cycle
//     pc_in, result_in       monitored PC and ALU result
//     rd_idx                 trace readback index, 0 = newest
//     rd_pc, rd_result       selected trace entry
//     entries, overflow      trace occupancy and sticky overwrite flag
//     cycle_count            RUN cycles elapsed
//     state, halted, timeout FSM state and terminal-state flags
module exec_trace_monitor
    import exec_trace_monitor_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 16,
    parameter int HALT_CYCLES = 4,
    parameter int MAX_CYCLES  = 1024,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sample_en,
    input  logic [XLEN-1:0]          pc_in,
    input  logic [XLEN-1:0]          result_in,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [XLEN-1:0]          rd_pc,
    output logic [XLEN-1:0]          rd_result,
    output logic [$clog2(DEPTH):0]   entries,
    output logic                     overflow,
    output logic [CNT_W-1:0]         cycle_count,
    output logic [1:0]               state,
    output logic                     halted,
    output logic                     timeout
);
    localparam int SW = $clog2(HALT_CYCLES + 1);
    localparam logic [SW-1:0]    HALT_V = SW'(HALT_CYCLES);
    localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(MAX_CYCLES);

    trace_state_e     state_q, state_d;
    logic [XLEN-1:0]  last_pc_q, last_pc_d;
    logic [SW-1:0]    stable_cnt_q, stable_cnt_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic             wr_en;

    always_comb begin
        state_d       = state_q;
        last_pc_d     = last_pc_q;
        stable_cnt_d  = stable_cnt_q;
        cycle_count_d = cycle_count_q;
        wr_en         = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (sample_en) begin
                    wr_en        = 1'b1;
                    last_pc_d    = pc_in;
                    stable_cnt_d = '0;
                    state_d      = ST_RUN;
                end
            end
            ST_RUN: begin
                cycle_count_d = cycle_count_q + CNT_W'(1);
                if (sample_en) begin
                    if (pc_in != last_pc_q) begin
                        wr_en        = 1'b1;
                        last_pc_d    = pc_in;
                        stable_cnt_d = '0;
                    end else begin
                        stable_cnt_d = stable_cnt_q + SW'(1);
                    end
                end
                // Halt takes precedence when both limits land on one edge.
                if (stable_cnt_d == HALT_V) begin
                    state_d = ST_HALTED;
                end else if (cycle_count_d == MAX_V) begin
                    state_d = ST_TIMEOUT;
                end
            end
            default: ;  // terminal states hold everything until reset
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            last_pc_q     <= '0;
            stable_cnt_q  <= '0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            last_pc_q     <= last_pc_d;
            stable_cnt_q  <= stable_cnt_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    trace_ring_buffer #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_pc     (pc_in),
        .wr_result (result_in),
        .rd_idx    (rd_idx),
        .rd_pc     (rd_pc),
        .rd_result (rd_result),
        .entries   (entries),
        .overflow  (overflow)
    );

    assign cycle_count = cycle_count_q;
    assign state       = state_q;
    assign halted      = (state_q == ST_HALTED);
    assign timeout     = (state_q == ST_TIMEOUT);

endmodule
